// File: rtl/stack_pkg.sv
// Shared types and default sizes for the stack controller and its storage.
package stack_pkg;

    localparam int unsigned DEPTH_DEFAULT = 256;
    localparam int unsigned WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        PUSH    = 2'd0,
        POP     = 2'd1,
        PEEK    = 2'd2,
        REPLACE = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_OUT  = 2'd2
    } state_e;

endpackage

// File: rtl/stack_ram.sv
// Single-port stack storage: synchronous write, registered read with one cycle of latency.
module stack_ram
    import stack_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/stack_ctrl.sv
// Hardware stack controller: PUSH/POP/PEEK/REPLACE over a single-port RAM with sticky error flags.
// Optional high-water-mark output enabled by defining STACK_CTRL_HWM_EN.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   op_valid,
    output logic                   op_ready,
    input  op_e                    op,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   rd_valid,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] sp,
    output logic                   err_overflow,
    output logic                   err_underflow
`ifdef STACK_CTRL_HWM_EN
    ,
    output logic [$clog2(DEPTH):0] hwm
`endif
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned SPW = AW + 1;

    state_e           state_q;
    state_e           state_d;
    logic [SPW-1:0]   sp_d;
    logic             ovf_d;
    logic             unf_d;
    logic             accept;
    logic             stack_full;
    logic             stack_empty;
    logic             ram_we;
    logic             ram_re;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_rdata;

    assign accept      = op_valid && op_ready;
    assign stack_full  = (sp == SPW'(DEPTH));
    assign stack_empty = (sp == '0);

    // Next-state, stack pointer and RAM command decode.
    always_comb begin
        state_d  = state_q;
        sp_d     = sp;
        ovf_d    = err_overflow;
        unf_d    = err_underflow;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = AW'(sp);

        case (state_q)
            RD_WAIT: begin
                state_d = RD_OUT;
            end
            IDLE, RD_OUT: begin
                state_d = IDLE;
                if (accept) begin
                    case (op)
                        PUSH: begin
                            if (stack_full) begin
                                ovf_d = 1'b1;
                            end else begin
                                ram_we   = 1'b1;
                                ram_addr = AW'(sp);
                                sp_d     = sp + SPW'(1);
                            end
                        end
                        REPLACE: begin
                            if (stack_empty) begin
                                unf_d = 1'b1;
                            end else begin
                                ram_we   = 1'b1;
                                ram_addr = AW'(sp - SPW'(1));
                            end
                        end
                        POP: begin
                            if (stack_empty) begin
                                unf_d = 1'b1;
                            end else begin
                                ram_re   = 1'b1;
                                ram_addr = AW'(sp - SPW'(1));
                                sp_d     = sp - SPW'(1);
                                state_d  = RD_WAIT;
                            end
                        end
                        PEEK: begin
                            if (stack_empty) begin
                                unf_d = 1'b1;
                            end else begin
                                ram_re   = 1'b1;
                                ram_addr = AW'(sp - SPW'(1));
                                state_d  = RD_WAIT;
                            end
                        end
                        default: begin
                            state_d = IDLE;
                        end
                    endcase
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs are decoded from the next state so they are registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            sp            <= '0;
            op_ready      <= 1'b1;
            rd_valid      <= 1'b0;
            rd_data       <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            state_q       <= state_d;
            sp            <= sp_d;
            op_ready      <= (state_d != RD_WAIT);
            rd_valid      <= (state_d == RD_OUT);
            err_overflow  <= ovf_d;
            err_underflow <= unf_d;
            if (state_q == RD_WAIT) begin
                rd_data <= ram_rdata;
            end
        end
    end

`ifdef STACK_CTRL_HWM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hwm <= '0;
        end else if (sp_d > hwm) begin
            hwm <= sp_d;
        end
    end
`endif

    stack_ram #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) memory (
        .clk  (clk),
        .we   (ram_we),
        .re   (ram_re),
        .addr (ram_addr),
        .wdata(wr_data),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_stack_ctrl.sv
// Scoreboard bench for stack_ctrl: queue-based stack model, directed cases plus random traffic.
// Also checks the hwm output when STACK_CTRL_HWM_EN is defined.
module tb_stack_ctrl;
    import stack_pkg::*;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             op_valid = 1'b0;
    op_e              op = PUSH;
    logic [WIDTH-1:0] wr_data = '0;
    logic             op_ready;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic [8:0]       sp;
    logic             err_overflow;
    logic             err_underflow;
`ifdef STACK_CTRL_HWM_EN
    logic [8:0]       hwm;
`endif

    stack_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) eval_stack (
        .clk          (clk),
        .rst          (rst),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op           (op),
        .wr_data      (wr_data),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .sp           (sp),
        .err_overflow (err_overflow),
        .err_underflow(err_underflow)
`ifdef STACK_CTRL_HWM_EN
        ,
        .hwm          (hwm)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               cyc;
    } exp_t;

    logic [WIDTH-1:0] stk[$];
    logic [WIDTH-1:0] mem_m [DEPTH];
    exp_t             exp_q[$];
    bit               ovf_m = 1'b0;
    bit               unf_m = 1'b0;
    int               hwm_m = 0;
    int               errors = 0;
    int               checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference stack: what an accepted op does to the abstract stack.
    task automatic model_apply(input op_e o, input logic [WIDTH-1:0] d);
        exp_t e;
        case (o)
            PUSH: begin
                if (stk.size() == DEPTH) ovf_m = 1'b1;
                else begin
                    mem_m[stk.size()] = d;
                    stk.push_back(d);
                end
            end
            REPLACE: begin
                if (stk.size() == 0) unf_m = 1'b1;
                else begin
                    stk[stk.size()-1]   = d;
                    mem_m[stk.size()-1] = d;
                end
            end
            POP: begin
                if (stk.size() == 0) unf_m = 1'b1;
                else begin
                    e.data = stk.pop_back();
                    e.cyc  = cyc + 2;
                    exp_q.push_back(e);
                end
            end
            default: begin
                if (stk.size() == 0) unf_m = 1'b1;
                else begin
                    e.data = stk[stk.size()-1];
                    e.cyc  = cyc + 2;
                    exp_q.push_back(e);
                end
            end
        endcase
        if (stk.size() > hwm_m) hwm_m = stk.size();
    endtask

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic issue(input op_e o, input logic [WIDTH-1:0] d, input bit want_ready_now);
        int n = 0;
        op_valid = 1'b1;
        op       = o;
        wr_data  = d;
        while (!op_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
            op_valid = 1'b0;
            return;
        end
        if (want_ready_now) chk("op_ready_b2b", 64'(n), 64'd0);
        model_apply(o, d);
        @(negedge clk);
        op_valid = 1'b0;
        chk("sp", 64'(sp), 64'(stk.size()));
        chk("err_overflow", 64'(err_overflow), 64'(ovf_m));
        chk("err_underflow", 64'(err_underflow), 64'(unf_m));
`ifdef STACK_CTRL_HWM_EN
        chk("hwm", 64'(hwm), 64'(hwm_m));
`endif
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Pulse reset starting at a falling edge; the model stack empties, memory persists.
    task automatic do_reset();
        rst = 1'b0;
        exp_q.delete();
        stk.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
        hwm_m = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_sp", 64'(sp), 64'd0);
        chk("rst_op_ready", 64'(op_ready), 64'd1);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_errs", 64'({err_overflow, err_underflow}), 64'd0);
`ifdef STACK_CTRL_HWM_EN
        chk("rst_hwm", 64'(hwm), 64'd0);
`endif
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Monitor: every rd_valid pulse must match the oldest outstanding read.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && rd_valid) begin
                if (exp_q.size() == 0) chk("unexpected_rd_valid", 64'd1, 64'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("rd_data", 64'(rd_data), 64'(e.data));
                    chk("rd_latency", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] v;
        logic [WIDTH-1:0] seq [4];
        int r;
        seq[0] = 32'h1; seq[1] = 32'h3; seq[2] = 32'h4; seq[3] = 32'hd;

        @(negedge clk);
        do_reset();

        // Back-to-back pushes then pops.
        for (int i = 0; i < 4; i++) issue(PUSH, seq[i], 1'b1);
        for (int i = 0; i < 4; i++) chk("mem_fill", 64'(eval_stack.memory.mem[i]), 64'(seq[i]));
        for (int i = 0; i < 4; i++) issue(POP, '0, 1'b0);
        drain();

        // PEEK, REPLACE, POP sequence and rd_data hold.
        issue(PUSH, 32'h5, 1'b0);
        issue(PEEK, '0, 1'b0);
        issue(REPLACE, 32'hd431, 1'b0);
        issue(POP, '0, 1'b0);
        drain();
        repeat (3) @(negedge clk);
        chk("rd_hold", 64'(rd_data), 64'h0000_d431);

        // Underflow and overflow boundaries.
        issue(POP, '0, 1'b0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < DEPTH + 1; i++) issue(PUSH, 32'(i + 1), 1'b1);
        chk("full_sp", 64'(sp), 64'(DEPTH));
        chk("mem_top", 64'(eval_stack.memory.mem[DEPTH-1]), 64'(DEPTH));
        issue(POP, '0, 1'b0);
        drain();

        // Reset during RD_WAIT aborts the read; memory survives.
        issue(PEEK, '0, 1'b0);
        do_reset();
        repeat (3) @(negedge clk);
        chk("mem_kept", 64'(eval_stack.memory.mem[0]), 64'(mem_m[0]));

        // High-water mark scenario (sp checked in both builds).
        for (int i = 0; i < 3; i++) issue(PUSH, 32'(i + 100), 1'b0);
        issue(POP, '0, 1'b0);
        issue(POP, '0, 1'b0);
        issue(PUSH, 32'h77, 1'b0);
        drain();
        chk("hwm_case_sp", 64'(sp), 64'd2);
`ifdef STACK_CTRL_HWM_EN
        chk("hwm_case_hwm", 64'(hwm), 64'd3);
`endif

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            v = $urandom;
            if (r < 45)      issue(PUSH, v, 1'b0);
            else if (r < 70) issue(POP, v, 1'b0);
            else if (r < 85) issue(PEEK, v, 1'b0);
            else             issue(REPLACE, v, 1'b0);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain();
        for (int i = 0; i < DEPTH; i += 17) begin
            chk("mem_final", 64'(eval_stack.memory.mem[i]), 64'(mem_m[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 256: number of stack entries, power of two.
REQ-002 SHALL have parameter WIDTH, default 32: entry width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port op_valid  input  1  request present.
REQ-006 SHALL have port op_ready  output  1  controller accepts a request this cycle.
REQ-007 SHALL have port op  input  2  opcode from stack_pkg: PUSH, POP, PEEK, REPLACE.
REQ-008 SHALL have port wr_data  input  WIDTH  operand for PUSH and REPLACE.
REQ-009 SHALL have port rd_valid  output  1  one-cycle pulse marking rd_data valid.
REQ-010 SHALL have port rd_data  output  WIDTH  result of POP or PEEK.
REQ-011 SHALL have port sp  output  $clog2(DEPTH)+1  current entry count.
REQ-012 SHALL have port err_overflow  output  1  sticky, PUSH attempted at sp == DEPTH.
REQ-013 SHALL have port err_underflow  output  1  sticky, POP, PEEK or REPLACE attempted at sp == 0.

Function
REQ-014 A request SHALL be accepted on a rising edge where op_valid and op_ready are both high.
REQ-015 FSM states SHALL be IDLE, RD_WAIT and RD_OUT; op_ready SHALL be high only in IDLE and RD_OUT.
REQ-016 PUSH SHALL write wr_data to mem[sp] and increment sp on the accept edge; the FSM stays in IDLE, so back-to-back PUSH runs at one per cycle.
REQ-017 REPLACE SHALL write wr_data to mem[sp-1] on the accept edge; sp is unchanged.
REQ-018 POP SHALL decrement sp on the accept edge, issue a read of mem[sp-1], and go to RD_WAIT.
REQ-019 PEEK SHALL issue a read of mem[sp-1], leave sp unchanged, and go to RD_WAIT.
REQ-020 RD_WAIT SHALL last exactly one cycle and then go to RD_OUT; rd_valid SHALL be high only in RD_OUT, the second cycle after acceptance.
REQ-021 In RD_OUT, a new request MAY be accepted; the FSM SHALL go to IDLE, or back to RD_WAIT for POP or PEEK.
REQ-022 rd_data SHALL hold its last value until the next read completes.
REQ-023 PUSH at sp == DEPTH SHALL be accepted without changing memory or sp and SHALL set err_overflow.
REQ-024 POP, PEEK or REPLACE at sp == 0 SHALL be accepted without changing memory or sp, SHALL set err_underflow, and SHALL NOT assert rd_valid.
REQ-025 Error flags SHALL stay set until reset.
REQ-026 When sp == DEPTH, a POP SHALL succeed normally.
REQ-027 The memory address SHALL be exactly $clog2(DEPTH) bits; sp never wraps.

Reset
REQ-028 While rst is low: FSM = IDLE, sp = 0, op_ready = 1, rd_valid = 0, rd_data = 0, both error flags = 0.
REQ-029 Asserting reset mid-read SHALL abort the read, with no rd_valid pulse afterwards.
REQ-030 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-031 Macro STACK_CTRL_HWM_EN defined: output hwm (width as sp) SHALL give the maximum sp seen since reset; it resets to 0 and updates on the same edge as sp.
REQ-032 Macro STACK_CTRL_HWM_EN undefined: port hwm and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-033 Package stack_pkg SHALL contain:
- the op enum typedef (PUSH=0, POP=1, PEEK=2, REPLACE=3);
- the FSM state enum;
- the DEPTH and WIDTH default constants.
REQ-034 Storage SHALL be a sub-module stack_ram:
- single port, synchronous write, registered read with 1-cycle latency;
- memory array named mem, so benches can reach eval_stack.memory.mem[i] hierarchically.

Verification
REQ-035 Reset, then PUSH 1, 3, 4, 0xd in consecutive cycles -> op_ready stays high; sp = 4; mem[0..3] = 1, 3, 4, 0xd.
REQ-036 From REQ-035, POP x4 back-to-back -> rd_valid pulses return 0xd, 4, 3, 1; each pulse is 2 cycles after its accept; sp = 0.
REQ-037 Push 5, PEEK, then REPLACE 0xd431, then POP -> PEEK returns 5; POP returns 0x0000d431; sp = 0.
REQ-038 POP at sp = 0 -> err_underflow = 1, no rd_valid, sp = 0; PUSH DEPTH+1 times -> err_overflow = 1, sp = DEPTH, mem[DEPTH-1] holds the DEPTH-th value.
REQ-039 PEEK accepted, rst pulsed low during RD_WAIT -> no rd_valid; sp = 0; op_ready = 1 after release.
REQ-040 With STACK_CTRL_HWM_EN: push 3, pop 2, push 1 -> hwm = 3, sp = 2.
